// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: bus widths, decode-bundle field
// offsets, one-hot ALU operation bit positions and the memory-bundle layout.
package exe_pkg;

  localparam int unsigned DS_BUS_W = 138;
  localparam int unsigned MS_BUS_W = 72;

  // Decode -> execute bundle field offsets (LSB positions)
  localparam int unsigned DS_PC_LSB        = 0;
  localparam int unsigned DS_ALU_OP_LSB    = 32;
  localparam int unsigned DS_SRC1_IS_SA    = 44;
  localparam int unsigned DS_SRC1_IS_PC    = 45;
  localparam int unsigned DS_SRC2_IS_IMM   = 46;
  localparam int unsigned DS_SRC2_IS_8     = 47;
  localparam int unsigned DS_SRC2_ZERO_EXT = 48;
  localparam int unsigned DS_IMM_LSB       = 49;
  localparam int unsigned DS_RS_LSB        = 65;
  localparam int unsigned DS_RT_LSB        = 97;
  localparam int unsigned DS_DEST_LSB      = 129;
  localparam int unsigned DS_GR_WE         = 134;
  localparam int unsigned DS_MEM_WE        = 135;
  localparam int unsigned DS_RES_FROM_MEM  = 136;
  localparam int unsigned DS_OVF_CHK       = 137;

  // One-hot ALU operation bit positions
  localparam int unsigned ALU_OP_W = 12;
  localparam int unsigned ALU_ADD  = 11;
  localparam int unsigned ALU_SUB  = 10;
  localparam int unsigned ALU_SLT  = 9;
  localparam int unsigned ALU_SLTU = 8;
  localparam int unsigned ALU_AND  = 7;
  localparam int unsigned ALU_NOR  = 6;
  localparam int unsigned ALU_OR   = 5;
  localparam int unsigned ALU_XOR  = 4;
  localparam int unsigned ALU_SLL  = 3;
  localparam int unsigned ALU_SRL  = 2;
  localparam int unsigned ALU_SRA  = 1;
  localparam int unsigned ALU_LUI  = 0;

  // Execute -> memory bundle, MSB first
  typedef struct packed {
    logic        ex_ovf;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } ms_bus_t;

  function automatic logic op_is_addsub(input logic [ALU_OP_W-1:0] op);
    return op[ALU_ADD] | op[ALU_SUB];
  endfunction

endpackage

// File: rtl/alu.sv
// Core ALU: one-hot operation select, shared adder for add/sub/slt/sltu.
module alu
  import exe_pkg::*;
(
  input  logic [ALU_OP_W-1:0] i_alu_op,
  input  logic [31:0]         i_src1,
  input  logic [31:0]         i_src2,
  output logic [31:0]         o_result
);

  logic        w_sub;
  logic [31:0] w_adder_b;
  logic [32:0] w_sum;
  logic        w_slt;
  logic        w_sltu;
  logic [4:0]  w_sa;

  assign w_sub     = i_alu_op[ALU_SUB] | i_alu_op[ALU_SLT] | i_alu_op[ALU_SLTU];
  assign w_adder_b = w_sub ? ~i_src2 : i_src2;
  assign w_sum     = {1'b0, i_src1} + {1'b0, w_adder_b} + {32'b0, w_sub};
  assign w_slt     = (i_src1[31] & ~i_src2[31]) |
                     (~(i_src1[31] ^ i_src2[31]) & w_sum[31]);
  assign w_sltu    = ~w_sum[32];
  assign w_sa      = i_src1[4:0];

  // AND-OR result mux over the one-hot operation
  always_comb begin
    o_result = '0;
    o_result |= {32{i_alu_op[ALU_ADD] | i_alu_op[ALU_SUB]}} & w_sum[31:0];
    o_result |= {32{i_alu_op[ALU_SLT]}}  & {31'b0, w_slt};
    o_result |= {32{i_alu_op[ALU_SLTU]}} & {31'b0, w_sltu};
    o_result |= {32{i_alu_op[ALU_AND]}}  & (i_src1 & i_src2);
    o_result |= {32{i_alu_op[ALU_NOR]}}  & ~(i_src1 | i_src2);
    o_result |= {32{i_alu_op[ALU_OR]}}   & (i_src1 | i_src2);
    o_result |= {32{i_alu_op[ALU_XOR]}}  & (i_src1 ^ i_src2);
    o_result |= {32{i_alu_op[ALU_SLL]}}  & (i_src2 << w_sa);
    o_result |= {32{i_alu_op[ALU_SRL]}}  & (i_src2 >> w_sa);
    o_result |= {32{i_alu_op[ALU_SRA]}}  & 32'($signed(i_src2) >>> w_sa);
    o_result |= {32{i_alu_op[ALU_LUI]}}  & {i_src2[15:0], 16'b0};
  end

endmodule

// File: rtl/exe_stage_src_sel.sv
// ALU operand selection for the execute stage (combinational).
module es_src_sel (
  input  logic        i_src1_is_sa,
  input  logic        i_src1_is_pc,
  input  logic        i_src2_is_imm,
  input  logic        i_src2_is_8,
  input  logic        i_src2_zero_ext,
  input  logic [31:0] i_pc,
  input  logic [15:0] i_imm,
  input  logic [31:0] i_rs_value,
  input  logic [31:0] i_rt_value,
  output logic [31:0] o_src1,
  output logic [31:0] o_src2
);

  // Priority muxes: shift amount > pc > rs; immediate > 8 > rt
  always_comb begin
    o_src1 = i_rs_value;
    if (i_src1_is_sa) begin
      o_src1 = {27'b0, i_imm[10:6]};
    end else if (i_src1_is_pc) begin
      o_src1 = i_pc;
    end
    o_src2 = i_rt_value;
    if (i_src2_is_imm) begin
      o_src2 = i_src2_zero_ext ? {16'b0, i_imm} : {{16{i_imm[15]}}, i_imm};
    end else if (i_src2_is_8) begin
      o_src2 = 32'd8;
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute pipeline stage: one-entry valid/allow-in register, operand select,
// ALU, data-SRAM request, bypass info to decode and hand-off to memory.
// Optional signed-overflow detection on add/sub is built when EXE_OVF_EN is
// defined; otherwise ex_ovf is tied low and ovf_chk is ignored.
module exe_stage
  import exe_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                ds_to_es_valid,
  input  logic [DS_BUS_W-1:0] ds_to_es_bus,
  output logic                es_allowin,
  output logic                es_to_ms_valid,
  input  logic                ms_allowin,
  output logic [MS_BUS_W-1:0] es_to_ms_bus,
  output logic                data_sram_en,
  output logic [3:0]          data_sram_wen,
  output logic [31:0]         data_sram_addr,
  output logic [31:0]         data_sram_wdata,
  output logic                es_fwd_valid,
  output logic [4:0]          es_fwd_dest,
  output logic [31:0]         es_fwd_data,
  output logic                es_fwd_is_load
);

  logic                r_es_valid;
  logic [DS_BUS_W-1:0] r_ds_bus;

  logic                w_es_ready_go;
  logic [31:0]         w_pc;
  logic [ALU_OP_W-1:0] w_alu_op;
  logic [15:0]         w_imm;
  logic [31:0]         w_rs_value;
  logic [31:0]         w_rt_value;
  logic [4:0]          w_dest;
  logic                w_gr_we;
  logic                w_mem_we;
  logic                w_res_from_mem;
  logic                w_ovf_chk;
  logic [31:0]         w_src1;
  logic [31:0]         w_src2;
  logic [31:0]         w_alu_result;
  logic                w_ovf_hit;
  ms_bus_t             w_ms_bus;

  assign w_es_ready_go = 1'b1;
  assign es_allowin     = !r_es_valid || (w_es_ready_go && ms_allowin);
  assign es_to_ms_valid = r_es_valid && w_es_ready_go && !flush;

  // Valid bit: reset/flush clear it, otherwise refill whenever allowed in
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_es_valid <= 1'b0;
    end else if (es_allowin) begin
      r_es_valid <= ds_to_es_valid;
    end
  end

  // Bundle register: capture only a real, non-flushed accept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ds_bus <= '0;
    end else if (ds_to_es_valid && es_allowin && !flush) begin
      r_ds_bus <= ds_to_es_bus;
    end
  end

  assign w_pc           = r_ds_bus[DS_PC_LSB +: 32];
  assign w_alu_op       = r_ds_bus[DS_ALU_OP_LSB +: ALU_OP_W];
  assign w_imm          = r_ds_bus[DS_IMM_LSB +: 16];
  assign w_rs_value     = r_ds_bus[DS_RS_LSB +: 32];
  assign w_rt_value     = r_ds_bus[DS_RT_LSB +: 32];
  assign w_dest         = r_ds_bus[DS_DEST_LSB +: 5];
  assign w_gr_we        = r_ds_bus[DS_GR_WE];
  assign w_mem_we       = r_ds_bus[DS_MEM_WE];
  assign w_res_from_mem = r_ds_bus[DS_RES_FROM_MEM];
  assign w_ovf_chk      = r_ds_bus[DS_OVF_CHK];

  es_src_sel u_src_sel (
    .i_src1_is_sa    (r_ds_bus[DS_SRC1_IS_SA]),
    .i_src1_is_pc    (r_ds_bus[DS_SRC1_IS_PC]),
    .i_src2_is_imm   (r_ds_bus[DS_SRC2_IS_IMM]),
    .i_src2_is_8     (r_ds_bus[DS_SRC2_IS_8]),
    .i_src2_zero_ext (r_ds_bus[DS_SRC2_ZERO_EXT]),
    .i_pc            (w_pc),
    .i_imm           (w_imm),
    .i_rs_value      (w_rs_value),
    .i_rt_value      (w_rt_value),
    .o_src1          (w_src1),
    .o_src2          (w_src2)
  );

  alu u_alu (
    .i_alu_op (w_alu_op),
    .i_src1   (w_src1),
    .i_src2   (w_src2),
    .o_result (w_alu_result)
  );

`ifdef EXE_OVF_EN
  logic [31:0] w_op2_eff;
  // Sub overflows like an add of the inverted operand
  assign w_op2_eff = w_alu_op[ALU_SUB] ? ~w_src2 : w_src2;
  assign w_ovf_hit = r_es_valid && w_ovf_chk && op_is_addsub(w_alu_op) &&
                     (w_src1[31] == w_op2_eff[31]) && (w_alu_result[31] != w_src1[31]);
`else
  logic w_unused_ovf_chk;
  assign w_unused_ovf_chk = w_ovf_chk;
  assign w_ovf_hit        = 1'b0;
`endif

  // Memory bundle; an overflowing instruction must not write the register file
  always_comb begin
    w_ms_bus              = '0;
    w_ms_bus.ex_ovf       = w_ovf_hit;
    w_ms_bus.res_from_mem = w_res_from_mem;
    w_ms_bus.gr_we        = w_gr_we && !w_ovf_hit;
    w_ms_bus.dest         = w_dest;
    w_ms_bus.alu_result   = w_alu_result;
    w_ms_bus.pc           = w_pc;
  end
  assign es_to_ms_bus = w_ms_bus;

  // Request only when memory will take the instruction this cycle
  assign data_sram_en    = r_es_valid && (w_mem_we || w_res_from_mem) && ms_allowin &&
                           !flush && !w_ovf_hit;
  assign data_sram_wen   = {4{data_sram_en && w_mem_we}};
  assign data_sram_addr  = w_alu_result;
  assign data_sram_wdata = w_rt_value;

  assign es_fwd_valid   = r_es_valid && w_gr_we && (w_dest != 5'd0) && !w_ovf_hit;
  assign es_fwd_dest    = w_dest;
  assign es_fwd_data    = w_alu_result;
  assign es_fwd_is_load = w_res_from_mem;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: vector table plus stall/flush/reset sequences.
module tb_exe_stage;
  import exe_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                flush;
  logic                ds_to_es_valid;
  logic [DS_BUS_W-1:0] ds_to_es_bus;
  logic                es_allowin;
  logic                es_to_ms_valid;
  logic                ms_allowin;
  logic [MS_BUS_W-1:0] es_to_ms_bus;
  logic                data_sram_en;
  logic [3:0]          data_sram_wen;
  logic [31:0]         data_sram_addr;
  logic [31:0]         data_sram_wdata;
  logic                es_fwd_valid;
  logic [4:0]          es_fwd_dest;
  logic [31:0]         es_fwd_data;
  logic                es_fwd_is_load;

  int n_cmp  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_allowin      (es_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .ms_allowin      (ms_allowin),
    .es_to_ms_bus    (es_to_ms_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .es_fwd_valid    (es_fwd_valid),
    .es_fwd_dest     (es_fwd_dest),
    .es_fwd_data     (es_fwd_data),
    .es_fwd_is_load  (es_fwd_is_load)
  );

  typedef struct {
    string       name;
    logic [11:0] op;
    logic        sa, ispc, isimm, is8, zext;
    logic [31:0] pc;
    logic [15:0] imm;
    logic [31:0] rs, rt;
    logic [4:0]  dest;
    logic        gr_we, mem_we, rfm, ovf_chk, ms_in;
    logic [31:0] res;
    logic        sram_en;
    logic [3:0]  wen;
    logic        fwd_v, ex_ovf, bus_we;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t base(input string name, input logic [11:0] op);
    vec_t v;
    v.name = name; v.op = op;
    v.sa = 0; v.ispc = 0; v.isimm = 0; v.is8 = 0; v.zext = 0;
    v.pc = 32'h0040_0000; v.imm = '0; v.rs = '0; v.rt = '0; v.dest = '0;
    v.gr_we = 0; v.mem_we = 0; v.rfm = 0; v.ovf_chk = 0; v.ms_in = 1;
    v.res = '0; v.sram_en = 0; v.wen = '0; v.fwd_v = 0; v.ex_ovf = 0; v.bus_we = 0;
    return v;
  endfunction

  function automatic logic [DS_BUS_W-1:0] pack(input vec_t v);
    return {v.ovf_chk, v.rfm, v.mem_we, v.gr_we, v.dest, v.rt, v.rs, v.imm,
            v.zext, v.is8, v.isimm, v.ispc, v.sa, v.op, v.pc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_vec(input vec_t v);
    chk({v.name, ".to_ms_valid"}, 32'(es_to_ms_valid), 32'd1);
    chk({v.name, ".pc"},          es_to_ms_bus[31:0], v.pc);
    chk({v.name, ".result"},      es_to_ms_bus[63:32], v.res);
    chk({v.name, ".dest"},        32'(es_to_ms_bus[68:64]), 32'(v.dest));
    chk({v.name, ".bus_gr_we"},   32'(es_to_ms_bus[69]), 32'(v.bus_we));
    chk({v.name, ".bus_rfm"},     32'(es_to_ms_bus[70]), 32'(v.rfm));
    chk({v.name, ".ex_ovf"},      32'(es_to_ms_bus[71]), 32'(v.ex_ovf));
    chk({v.name, ".sram_en"},     32'(data_sram_en), 32'(v.sram_en));
    chk({v.name, ".sram_wen"},    32'(data_sram_wen), 32'(v.wen));
    chk({v.name, ".fwd_valid"},   32'(es_fwd_valid), 32'(v.fwd_v));
    if (v.sram_en) begin
      chk({v.name, ".sram_addr"},  data_sram_addr, v.res);
      chk({v.name, ".sram_wdata"}, data_sram_wdata, v.rt);
    end
    if (v.fwd_v) begin
      chk({v.name, ".fwd_data"},    es_fwd_data, v.res);
      chk({v.name, ".fwd_dest"},    32'(es_fwd_dest), 32'(v.dest));
      chk({v.name, ".fwd_is_load"}, 32'(es_fwd_is_load), 32'(v.rfm));
    end
  endtask

  function automatic logic [11:0] oh(input int unsigned bitpos);
    logic [11:0] r;
    r = '0;
    r[bitpos] = 1'b1;
    return r;
  endfunction

  initial begin
    vec_t v;
    vec_t va;
    vec_t vb;

    // ---------------- vector table ----------------
    v = base("addiu", oh(ALU_ADD)); v.isimm = 1; v.imm = 16'hFFFF; v.rs = 32'h10;
    v.dest = 5; v.gr_we = 1; v.res = 32'hF; v.fwd_v = 1; v.bus_we = 1; tbl.push_back(v);
    v = base("sll", oh(ALU_SLL)); v.sa = 1; v.imm = 16'h0100; v.rt = 32'h1;
    v.dest = 3; v.gr_we = 1; v.res = 32'h10; v.fwd_v = 1; v.bus_we = 1; tbl.push_back(v);
    v = base("sw", oh(ALU_ADD)); v.isimm = 1; v.imm = 16'h8; v.rs = 32'h1000;
    v.rt = 32'hDEAD_BEEF; v.mem_we = 1; v.res = 32'h1008; v.sram_en = 1; v.wen = 4'hF;
    tbl.push_back(v);
    v = base("lw", oh(ALU_ADD)); v.isimm = 1; v.imm = 16'hFFFC; v.rs = 32'h2000;
    v.rfm = 1; v.gr_we = 1; v.dest = 8; v.res = 32'h1FFC; v.sram_en = 1; v.fwd_v = 1;
    v.bus_we = 1; tbl.push_back(v);
    v = base("lw_stalled", oh(ALU_ADD)); v.isimm = 1; v.imm = 16'h4; v.rs = 32'h3000;
    v.rfm = 1; v.gr_we = 1; v.dest = 9; v.ms_in = 0; v.res = 32'h3004; v.fwd_v = 1;
    v.bus_we = 1; tbl.push_back(v);
    v = base("jal", oh(ALU_ADD)); v.ispc = 1; v.is8 = 1; v.pc = 32'hBFC0_0000;
    v.dest = 31; v.gr_we = 1; v.res = 32'hBFC0_0008; v.fwd_v = 1; v.bus_we = 1;
    tbl.push_back(v);
    v = base("ori", oh(ALU_OR)); v.isimm = 1; v.zext = 1; v.imm = 16'h8001;
    v.rs = 32'h1234_0000; v.dest = 4; v.gr_we = 1; v.res = 32'h1234_8001; v.fwd_v = 1;
    v.bus_we = 1; tbl.push_back(v);
    v = base("lui", oh(ALU_LUI)); v.isimm = 1; v.imm = 16'hABCD; v.dest = 6;
    v.gr_we = 1; v.res = 32'hABCD_0000; v.fwd_v = 1; v.bus_we = 1; tbl.push_back(v);
    v = base("slt", oh(ALU_SLT)); v.rs = 32'hFFFF_FFFF; v.rt = 32'h1; v.dest = 7;
    v.gr_we = 1; v.res = 32'h1; v.fwd_v = 1; v.bus_we = 1; tbl.push_back(v);
    v = base("sltu", oh(ALU_SLTU)); v.rs = 32'hFFFF_FFFF; v.rt = 32'h1; v.dest = 7;
    v.gr_we = 1; v.res = 32'h0; v.fwd_v = 1; v.bus_we = 1; tbl.push_back(v);
    v = base("sra", oh(ALU_SRA)); v.sa = 1; v.imm = 16'h0100; v.rt = 32'h8000_0000;
    v.dest = 10; v.gr_we = 1; v.res = 32'hF800_0000; v.fwd_v = 1; v.bus_we = 1;
    tbl.push_back(v);
    v = base("subu", oh(ALU_SUB)); v.rs = 32'h5; v.rt = 32'h7; v.dest = 11;
    v.gr_we = 1; v.res = 32'hFFFF_FFFE; v.fwd_v = 1; v.bus_we = 1; tbl.push_back(v);
    v = base("nor", oh(ALU_NOR)); v.rt = 32'hF0F0_F0F0; v.dest = 12; v.gr_we = 1;
    v.res = 32'h0F0F_0F0F; v.fwd_v = 1; v.bus_we = 1; tbl.push_back(v);
    v = base("dest0", oh(ALU_ADD)); v.rs = 32'h1; v.rt = 32'h2; v.dest = 0;
    v.gr_we = 1; v.res = 32'h3; v.fwd_v = 0; v.bus_we = 1; tbl.push_back(v);
    v = base("add_ovf", oh(ALU_ADD)); v.ovf_chk = 1; v.rs = 32'h7FFF_FFFF; v.rt = 32'h1;
    v.dest = 2; v.gr_we = 1; v.res = 32'h8000_0000;
`ifdef EXE_OVF_EN
    v.ex_ovf = 1; v.bus_we = 0; v.fwd_v = 0;
`else
    v.ex_ovf = 0; v.bus_we = 1; v.fwd_v = 1;
`endif
    tbl.push_back(v);
    v = base("sub_ovf", oh(ALU_SUB)); v.ovf_chk = 1; v.rs = 32'h8000_0000; v.rt = 32'h1;
    v.dest = 13; v.gr_we = 1; v.res = 32'h7FFF_FFFF;
`ifdef EXE_OVF_EN
    v.ex_ovf = 1; v.bus_we = 0; v.fwd_v = 0;
`else
    v.ex_ovf = 0; v.bus_we = 1; v.fwd_v = 1;
`endif
    tbl.push_back(v);
    v = base("add_no_ovf", oh(ALU_ADD)); v.ovf_chk = 1; v.rs = 32'h1; v.rt = 32'h1;
    v.dest = 14; v.gr_we = 1; v.res = 32'h2; v.fwd_v = 1; v.bus_we = 1; tbl.push_back(v);

    // ---------------- reset ----------------
    reset = 1; flush = 0; ds_to_es_valid = 0; ds_to_es_bus = '0; ms_allowin = 1;
    repeat (2) @(negedge clk);
    chk("reset.allowin",     32'(es_allowin), 32'd1);
    chk("reset.to_ms_valid", 32'(es_to_ms_valid), 32'd0);
    chk("reset.sram_en",     32'(data_sram_en), 32'd0);
    chk("reset.sram_wen",    32'(data_sram_wen), 32'd0);
    chk("reset.fwd_valid",   32'(es_fwd_valid), 32'd0);
    chk("reset.bus",         es_to_ms_bus[63:32], 32'd0);
    reset = 0;

    // ---------------- table ----------------
    foreach (tbl[i]) begin
      @(negedge clk);
      ms_allowin = tbl[i].ms_in; ds_to_es_valid = 1; ds_to_es_bus = pack(tbl[i]);
      @(negedge clk);
      ds_to_es_valid = 0;
      check_vec(tbl[i]);
      ms_allowin = 1;
      @(negedge clk);
      chk({tbl[i].name, ".drained"}, 32'(es_to_ms_valid), 32'd0);
    end

    // ---------------- stall, reissue, then flush ----------------
    va = tbl[2];             // sw
    vb = tbl[0]; vb.pc = 32'h0000_5555;
    @(negedge clk);
    ms_allowin = 0; ds_to_es_valid = 1; ds_to_es_bus = pack(va);
    @(negedge clk);
    ds_to_es_bus = pack(vb);  // offered during the stall, must not be taken
    for (int c = 0; c < 3; c++) begin
      chk("stall.allowin",     32'(es_allowin), 32'd0);
      chk("stall.sram_en",     32'(data_sram_en), 32'd0);
      chk("stall.to_ms_valid", 32'(es_to_ms_valid), 32'd1);
      chk("stall.pc",          es_to_ms_bus[31:0], va.pc);
      chk("stall.result",      es_to_ms_bus[63:32], va.res);
      @(negedge clk);
    end
    ms_allowin = 1; #1;
    chk("reissue.sram_en",  32'(data_sram_en), 32'd1);
    chk("reissue.sram_wen", 32'(data_sram_wen), 32'hF);
    ms_allowin = 0; flush = 1; #1;
    chk("flush.to_ms_valid", 32'(es_to_ms_valid), 32'd0);
    chk("flush.sram_en",     32'(data_sram_en), 32'd0);
    @(negedge clk);
    flush = 0; ds_to_es_valid = 0; ms_allowin = 1;
    chk("postflush.allowin",     32'(es_allowin), 32'd1);
    chk("postflush.to_ms_valid", 32'(es_to_ms_valid), 32'd0);

    // ---------------- flush beats a simultaneous offer ----------------
    @(negedge clk);
    ds_to_es_valid = 1; ds_to_es_bus = pack(tbl[0]); flush = 1;
    @(negedge clk);
    ds_to_es_valid = 0; flush = 0;
    chk("flush_vs_accept.to_ms_valid", 32'(es_to_ms_valid), 32'd0);
    chk("flush_vs_accept.fwd_valid",   32'(es_fwd_valid), 32'd0);

    // ---------------- back-to-back: accept replaces handed-off entry ----------------
    va = tbl[0]; va.pc = 32'h0000_0100;
    vb = tbl[5];             // jal
    @(negedge clk);
    ds_to_es_valid = 1; ds_to_es_bus = pack(va);
    @(negedge clk);
    ds_to_es_bus = pack(vb);
    chk("b2b.first_pc",  es_to_ms_bus[31:0], va.pc);
    chk("b2b.allowin",   32'(es_allowin), 32'd1);
    @(negedge clk);
    ds_to_es_valid = 0;
    chk("b2b.second_pc",     es_to_ms_bus[31:0], vb.pc);
    chk("b2b.second_result", es_to_ms_bus[63:32], vb.res);
    chk("b2b.to_ms_valid",   32'(es_to_ms_valid), 32'd1);
    @(negedge clk);

    // ---------------- reset during a stall ----------------
    @(negedge clk);
    ms_allowin = 0; ds_to_es_valid = 1; ds_to_es_bus = pack(tbl[3]);
    @(negedge clk);
    ds_to_es_valid = 0;
    chk("rst_stall.held",    32'(es_to_ms_valid), 32'd1);
    chk("rst_stall.allowin", 32'(es_allowin), 32'd0);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rst_stall.to_ms_valid", 32'(es_to_ms_valid), 32'd0);
    chk("rst_stall.allowin_after", 32'(es_allowin), 32'd1);
    chk("rst_stall.fwd_valid", 32'(es_fwd_valid), 32'd0);
    ms_allowin = 1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute pipeline stage of the five-stage MIPS core, between decode and memory. It holds one instruction in a valid/allow-in pipeline register and selects the ALU operands from the decode bundle. It drives the core's `alu` module and issues the data-SRAM request. It forwards the result to decode and hands the completed bundle to the memory stage.

## Interface
- `DS_BUS_W`, 138: decode→execute bundle width.
- `MS_BUS_W`, 72: execute→memory bundle width.
- `clk` in 1: sole clock; all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: discard held instruction (exception/eret from later stage).
- `ds_to_es_valid` in 1: decode offers instruction.
- `ds_to_es_bus` in 138, LSB first:
  - pc[31:0], alu_op[43:32] (12-bit one-hot, ALU encoding)
  - src1_is_sa[44], src1_is_pc[45], src2_is_imm[46], src2_is_8[47], src2_zero_ext[48]
  - imm[64:49], rs_value[96:65], rt_value[128:97], dest[133:129]
  - gr_we[134], mem_we[135], res_from_mem[136], ovf_chk[137]
- `es_allowin` out 1: execute can accept.
- `es_to_ms_valid` out 1: bundle valid to memory.
- `ms_allowin` in 1: memory can accept.
- `es_to_ms_bus` out 72:
  - pc[31:0], alu_result[63:32], dest[68:64]
  - gr_we[69], res_from_mem[70], ex_ovf[71]
- `data_sram_en` out 1, `data_sram_wen` out 4, `data_sram_addr` out 32, `data_sram_wdata` out 32: fixed one-cycle-latency SRAM request.
- `es_fwd_valid` out 1, `es_fwd_dest` out 5, `es_fwd_data` out 32, `es_fwd_is_load` out 1: bypass/load-use info to decode.

## Operation
- State: `es_valid` plus registered copy of ds bundle.
- es_ready_go = 1 (single-cycle stage).
- es_allowin = !es_valid || (es_ready_go && ms_allowin).
- es_to_ms_valid = es_valid && es_ready_go && !flush.
- src1 priority: src1_is_sa → {27'b0, imm[10:6]}; else src1_is_pc → pc; else rs_value.
- src2 priority: src2_is_imm → (src2_zero_ext ? {16'b0,imm} : {{16{imm[15]}},imm}); else src2_is_8 → 32'd8; else rt_value.
- ALU shifts use src1[4:0] as amount and src2 as data. lui uses src2[15:0].
- data_sram_addr = alu_result and data_sram_wdata = rt_value.
- data_sram_en = es_valid && (mem_we||res_from_mem) && ms_allowin && !flush && !ovf_hit.
- data_sram_wen = {4{data_sram_en && mem_we}}.
- Forwarding:
  - es_fwd_valid = es_valid && gr_we && dest!=0 && !ovf_hit.
  - es_fwd_data = alu_result.
  - es_fwd_is_load = res_from_mem.

## Timing
- Reset: es_valid=0, bundle regs=0. Consequently es_allowin=1, es_to_ms_valid=0, data_sram_en=0, wen=0, es_fwd_valid=0.
- Each edge, by priority:
  - reset or flush: es_valid←0.
  - else if es_allowin: es_valid←ds_to_es_valid.
- Bundle regs load iff ds_to_es_valid && es_allowin && !flush.
- Latency: one cycle decode-accept to es_to_ms_valid. Results are combinational from registered bundle.
- ms_allowin=0 with es_valid=1: hold bundle, es_allowin=0, SRAM request suppressed. Request is reissued when ms_allowin rises.
- Simultaneous flush and ds_to_es_valid: flush wins, nothing captured.
- Simultaneous accept and hand-off: new instruction replaces old in the same edge.
- Reset mid-stall: valid cleared regardless of ms_allowin.

## Configuration
- `EXE_OVF_EN` defined:
  - ovf_hit = es_valid && ovf_chk && alu_op is add/sub && (op1[31]==op2eff[31]) && (result[31]!=op1[31]), where op2eff = ~src2 for sub.
  - On hit: ex_ovf=1, bus gr_we forced 0, SRAM and forwarding suppressed.
- Undefined:
  - ovf_hit and ex_ovf tied 0 and ovf_chk ignored.
  - Bus widths unchanged.

## Structure
- Package `exe_pkg`: DS_BUS_W/MS_BUS_W, field offset localparams, ALU one-hot op constants (ADD=bit11 … LUI=bit0).
- Instantiates existing `alu`.
- One sub-module: `es_src_sel` (combinational src1/src2 mux).

## Test plan
- addiu: rs=0x0000_0010, imm=0xFFFF, src2_is_imm → cycle after accept, es_to_ms_valid=1, alu_result=0x0000_000F, fwd dest/data match.
- sll: sa=4 (imm[10:6]=4), rt=0x0000_0001 → result 0x0000_0010.
- sw: rs=0x1000, imm=8, rt=0xDEAD_BEEF, ms_allowin=1 → data_sram_en=1, wen=4'hF, addr=0x1008, wdata=0xDEAD_BEEF.
- Stall then flush:
  - ms_allowin=0 for 3 cycles → bundle stable, es_allowin=0, sram_en=0.
  - Assert flush → next cycle es_valid=0, es_allowin=1.
- jal link: src1_is_pc, pc=0xBFC0_0000, src2_is_8 → result 0xBFC0_0008.
- With EXE_OVF_EN: add, ovf_chk, rs=0x7FFF_FFFF, rt=1 → ex_ovf=1, bus gr_we=0, es_fwd_valid=0. Same stimulus without the macro → ex_ovf=0, result 0x8000_0000.
